// File: rtl/booth_share_pkg.sv
// Shared constants for the booth multiplier sharing controller:
// FSM state encodings, default sizing and a constant-friendly clog2.
package booth_share_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 63;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_RESP = 3'd2;
    localparam logic [2:0] ST_ERR  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/booth_mult_share_ctrl_if.sv
// Requester and multiplier signals of the sharing controller; the controller
// uses the slave view, the surrounding system the master view.
interface booth_mult_share_ctrl_if
    import booth_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int DW    = DEF_DW
);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [2*DW-1:0]     rsp_product;
    logic                rsp_err;
    logic                busy;
    logic                mul_start;
    logic [DW-1:0]       mul_a;
    logic [DW-1:0]       mul_b;
    logic                mul_done;
    logic [2*DW-1:0]     mul_product;

    modport slave (
        input  req_valid, req_a, req_b, mul_done, mul_product,
        output req_ready, rsp_valid, rsp_product, rsp_err, busy,
               mul_start, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, mul_done, mul_product,
        input  req_ready, rsp_valid, rsp_product, rsp_err, busy,
               mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request bit at or above ptr,
// wrapping past N_REQ-1 back to 0.
module rr_pick
    import booth_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int PW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             any,
    output logic [PW-1:0]    idx
);

    // Walk the offsets downward so the smallest offset from ptr wins.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N_REQ]) begin
                idx = PW'((int'(ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/booth_mult_share_ctrl.sv
// Arbitrates N_REQ requesters onto one booth multiplier, sequences its
// start/done handshake and aborts via a watchdog if it never answers.
module booth_mult_share_ctrl
    import booth_share_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic                    clk,
    input logic                    rst_n,
    booth_mult_share_ctrl_if.slave bus
);

    localparam int PW = clog2(N_REQ);
    localparam int WW = clog2(TIMEOUT + 1);

    logic [2:0]       state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    grant_q, grant_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [2*DW-1:0]  prod_q, prod_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [2*DW-1:0]  rsp_product_q, rsp_product_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;
    logic             mul_start_q, mul_start_d;
    logic [DW-1:0]    mul_a_q, mul_a_d;
    logic [DW-1:0]    mul_b_q, mul_b_d;

    logic             pick_any;
    logic [PW-1:0]    pick_idx;
    logic [WW-1:0]    wdog_inc;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // The watchdog value compared includes the current RUN cycle, so
    // mul_start stays high for at most TIMEOUT cycles.
    assign wdog_inc = wdog_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        wdog_d        = wdog_q;
        prod_d        = prod_q;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_product_d = rsp_product_q;
        rsp_err_d     = 1'b0;
        mul_start_d   = mul_start_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d               = pick_idx;
                    mul_a_d               = bus.req_a[pick_idx*DW +: DW];
                    mul_b_d               = bus.req_b[pick_idx*DW +: DW];
                    req_ready_d[pick_idx] = 1'b1;
                    mul_start_d           = 1'b1;
                    wdog_d                = '0;
                    rr_ptr_d              = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d               = ST_RUN;
                end
            end
            ST_RUN: begin
                wdog_d = wdog_inc;
                if (bus.mul_done) begin
                    prod_d      = bus.mul_product;
                    mul_start_d = 1'b0;
                    state_d     = ST_RESP;
                end else if (wdog_inc == WW'(TIMEOUT)) begin
                    mul_start_d = 1'b0;
                    state_d     = ST_ERR;
                end
            end
            ST_RESP: begin
                rsp_valid_d[grant_q] = 1'b1;
                rsp_product_d        = prod_q;
                mul_start_d          = 1'b0;
                state_d              = ST_GAP;
            end
            ST_ERR: begin
                rsp_valid_d[grant_q] = 1'b1;
                rsp_product_d        = '0;
                rsp_err_d            = 1'b1;
                mul_start_d          = 1'b0;
                state_d              = ST_GAP;
            end
            ST_GAP: begin
                mul_start_d = 1'b0;
                if (!bus.mul_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                mul_start_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            wdog_q        <= '0;
            prod_q        <= '0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            mul_start_q   <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            wdog_q        <= wdog_d;
            prod_q        <= prod_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
            rsp_err_q     <= rsp_err_d;
            busy_q        <= busy_d;
            mul_start_q   <= mul_start_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_product = rsp_product_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = busy_q;
    assign bus.mul_start   = mul_start_q;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;

endmodule

// File: tb/tb_booth_mult_share_ctrl.sv
// Directed bench for booth_mult_share_ctrl with a behavioural 10-cycle
// multiplier that can be made stuck or told to hold done high.
module tb_booth_mult_share_ctrl;
    import booth_share_pkg::*;

    localparam int N_REQ   = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 63;
    localparam int LAT     = 10;

    typedef struct {
        int          idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_product;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int pass_count  = 0;
    int check_count = 0;

    logic stuck      = 1'b0;
    int   extra_hold = 0;
    logic m_active;
    logic m_wait_low;
    int   m_cnt;
    int   m_hold;

    always #5 clk = ~clk;

    booth_mult_share_ctrl_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

    booth_mult_share_ctrl #(
        .N_REQ   (N_REQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Multiplier model: answers LAT cycles after start, once per start pulse,
    // optionally never (stuck) or with done held for extra_hold more cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active        <= 1'b0;
            m_wait_low      <= 1'b0;
            m_cnt           <= 0;
            m_hold          <= 0;
            bus.mul_done    <= 1'b0;
            bus.mul_product <= '0;
        end else begin
            if (m_hold > 0) begin
                bus.mul_done <= 1'b1;
                m_hold       <= m_hold - 1;
            end else begin
                bus.mul_done <= 1'b0;
            end
            if (m_wait_low && !bus.mul_start) begin
                m_wait_low <= 1'b0;
            end
            if (!m_active) begin
                if (bus.mul_start && !m_wait_low) begin
                    m_active <= 1'b1;
                    m_cnt    <= 1;
                end
            end else if (!bus.mul_start) begin
                m_active <= 1'b0;
            end else if (!stuck && m_cnt >= LAT) begin
                bus.mul_done    <= 1'b1;
                bus.mul_product <= $signed(bus.mul_a) * $signed(bus.mul_b);
                m_active        <= 1'b0;
                m_wait_low      <= 1'b1;
                m_hold          <= extra_hold;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[idx*DW +: DW] = a;
        bus.req_b[idx*DW +: DW] = b;
        bus.req_valid[idx]      = 1'b1;
    endtask

    task automatic waitIdle();
        for (int c = 0; c < 300; c++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
    endtask

    task automatic waitReady(output logic [N_REQ-1:0] got);
        got = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                got = bus.req_ready;
                break;
            end
        end
    endtask

    task automatic waitRsp(output logic [N_REQ-1:0] got, output int cycles);
        got    = '0;
        cycles = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            cycles++;
            if (bus.rsp_valid != '0) begin
                got = bus.rsp_valid;
                break;
            end
        end
    endtask

    // One isolated transaction, including the ready and response timing.
    task automatic runSingle(input int idx, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp_product, input string name);
        int done_at;
        int rsp_at;
        logic seen;
        waitIdle();
        applyStimulus(idx, a, b);
        @(negedge clk);
        checkOutput({name, "_ready"}, 32'(bus.req_ready), 32'(1 << idx));
        checkOutput({name, "_mul_ab"}, 32'({bus.mul_a, bus.mul_b}), 32'({a, b}));
        bus.req_valid[idx] = 1'b0;
        done_at = -100;
        rsp_at  = 0;
        seen    = 1'b0;
        for (int c = 1; c < 300; c++) begin
            @(negedge clk);
            if (bus.mul_done && done_at < 0) done_at = c;
            if (bus.rsp_valid != '0) begin
                rsp_at = c;
                seen   = 1'b1;
                break;
            end
        end
        checkOutput({name, "_rsp_valid"}, 32'(bus.rsp_valid), seen ? 32'(1 << idx) : 32'hFFFF);
        checkOutput({name, "_product"}, 32'(bus.rsp_product), 32'(exp_product));
        checkOutput({name, "_err"}, 32'(bus.rsp_err), 32'd0);
        checkOutput({name, "_rsp_latency"}, 32'(rsp_at - done_at), 32'd2);
        checkOutput({name, "_start_low"}, 32'(bus.mul_start), 32'd0);
        @(negedge clk);
        checkOutput({name, "_rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        vec_t vecs[6];
        vec_t multi[4];
        logic [N_REQ-1:0] got;
        int cycles;
        int gap_cycles;

        vecs[0] = '{0, 8'd2,    8'd4,    16'h0008};
        vecs[1] = '{1, 8'hFD,   8'd7,    16'hFFEB};
        vecs[2] = '{2, 8'd127,  8'd127,  16'h3F01};
        vecs[3] = '{3, 8'h80,   8'h80,   16'h4000};
        vecs[4] = '{1, 8'h80,   8'd127,  16'hC080};
        vecs[5] = '{2, 8'd0,    8'hFB,   16'h0000};

        multi[0] = '{0, 8'hFC,  8'd5,    16'hFFEC};
        multi[1] = '{1, 8'd36,  8'hF8,   16'hFEE0};
        multi[2] = '{2, 8'h81,  8'h81,   16'h3F01};
        multi[3] = '{3, 8'd2,   8'd4,    16'h0008};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_product", 32'(bus.rsp_product), 32'd0);
        checkOutput("reset_flags", 32'({bus.rsp_err, bus.busy, bus.mul_start}), 32'd0);
        checkOutput("reset_mul_ab", 32'({bus.mul_a, bus.mul_b}), 32'd0);
        rst_n = 1'b1;

        // All four requesters at once: grants must rotate 0,1,2,3.
        for (int k = 0; k < 4; k++) applyStimulus(multi[k].idx, multi[k].a, multi[k].b);
        for (int k = 0; k < 4; k++) begin
            waitReady(got);
            checkOutput($sformatf("multi_grant%0d", k), 32'(got), 32'(1 << multi[k].idx));
            bus.req_valid[multi[k].idx] = 1'b0;
            waitRsp(got, cycles);
            checkOutput($sformatf("multi_rsp%0d", k), 32'(got), 32'(1 << multi[k].idx));
            checkOutput($sformatf("multi_product%0d", k), 32'(bus.rsp_product), 32'(multi[k].exp_product));
        end

        // Pointer moves past requester 1, so 3 beats 0.
        runSingle(1, 8'd1, 8'd1, 16'h0001, "rr_setup");
        waitIdle();
        applyStimulus(0, 8'd3, 8'd2);
        applyStimulus(3, 8'd5, 8'd2);
        waitReady(got);
        checkOutput("rr_first_grant", 32'(got), 32'b1000);
        bus.req_valid[3] = 1'b0;
        waitRsp(got, cycles);
        checkOutput("rr_first_product", 32'(bus.rsp_product), 32'h000A);
        waitReady(got);
        checkOutput("rr_second_grant", 32'(got), 32'b0001);
        bus.req_valid[0] = 1'b0;
        waitRsp(got, cycles);
        checkOutput("rr_second_product", 32'(bus.rsp_product), 32'h0006);

        for (int i = 0; i < 6; i++) begin
            runSingle(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].exp_product, $sformatf("vec%0d", i));
        end

        // Stuck multiplier: error response TIMEOUT+1 cycles after start.
        stuck = 1'b1;
        waitIdle();
        applyStimulus(0, 8'd1, 8'd1);
        waitReady(got);
        checkOutput("stuck_start", 32'(bus.mul_start), 32'd1);
        bus.req_valid[0] = 1'b0;
        waitRsp(got, cycles);
        checkOutput("stuck_latency", 32'(cycles), 32'(TIMEOUT + 1));
        checkOutput("stuck_rsp_valid", 32'(got), 32'b0001);
        checkOutput("stuck_err", 32'(bus.rsp_err), 32'd1);
        checkOutput("stuck_product", 32'(bus.rsp_product), 32'd0);
        stuck = 1'b0;
        runSingle(3, 8'hFF, 8'd1, 16'hFFFF, "after_stuck");

        // Reset while the multiplier is running.
        waitIdle();
        applyStimulus(2, 8'd2, 8'd4);
        waitReady(got);
        bus.req_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_start", 32'(bus.mul_start), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_start", 32'(bus.mul_start), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_rsp_product", 32'(bus.rsp_product), 32'd0);
        checkOutput("midrst_mul_ab", 32'({bus.mul_a, bus.mul_b}), 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        runSingle(0, 8'd2, 8'd4, 16'h0008, "post_reset");

        // Done held into GAP: no new start until it falls.
        extra_hold = 4;
        waitIdle();
        applyStimulus(1, 8'd3, 8'd3);
        waitReady(got);
        checkOutput("hold_grant", 32'(got), 32'b0010);
        bus.req_valid[1] = 1'b0;
        applyStimulus(2, 8'd5, 8'd5);
        waitRsp(got, cycles);
        extra_hold = 0;
        checkOutput("hold_product", 32'(bus.rsp_product), 32'h0009);
        gap_cycles = 0;
        got = '0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            gap_cycles++;
            if (bus.mul_done) checkOutput("hold_start_low", 32'(bus.mul_start), 32'd0);
            if (bus.req_ready != '0) begin
                got = bus.req_ready;
                break;
            end
        end
        checkOutput("hold_turnaround", 32'(gap_cycles), 32'd5);
        checkOutput("hold_next_grant", 32'(got), 32'b0100);
        bus.req_valid[2] = 1'b0;
        waitRsp(got, cycles);
        checkOutput("hold_next_product", 32'(bus.rsp_product), 32'h0019);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/booth_mult_share_ctrl.md
Name: booth_mult_share_ctrl

Overview:
Shares one booth multiplier (start_sig/done_sig handshake, signed 8x8 -> 16 product) among N_REQ requesters. Round-robin arbitration picks one requester. The block latches its operands, sequences the multiplier's start/done handshake and returns the product to that requester with a one-cycle response pulse. A watchdog aborts a transaction if the multiplier never answers, so no requester can hang the shared resource.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, operand width; product width is 2*DW
TIMEOUT, 63, maximum cycles mul_start stays high waiting for mul_done before abort

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  N_REQ  per-requester request; held with operands until req_ready seen
req_a  in  N_REQ*DW  packed signed multiplicands, requester k at [k*DW +: DW]
req_b  in  N_REQ*DW  packed signed multipliers, same packing
req_ready  out  N_REQ  one-hot, one-cycle pulse: request accepted, operands latched
rsp_valid  out  N_REQ  one-hot, one-cycle pulse: result for that requester
rsp_product  out  2*DW  signed product, valid only while any rsp_valid bit is high
rsp_err  out  1  high with rsp_valid when the transaction timed out
busy  out  1  high in every state except IDLE
mul_start  out  1  start to multiplier
mul_a  out  DW  operand A to multiplier, stable while mul_start high
mul_b  out  DW  operand B to multiplier, stable while mul_start high
mul_done  in  1  multiplier done
mul_product  in  2*DW  multiplier product, sampled on the cycle mul_done is high

Behaviour:
- Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_product=0, rsp_err=0, busy=0, mul_start=0, mul_a=0, mul_b=0, watchdog=0. Reset mid-transaction aborts it silently with no rsp_valid; the multiplier sees mul_start fall.
- All outputs are registered.
- FSM states:
  - IDLE: on the edge where any req_valid is set, grant g = first set bit searching upward from rr_ptr with wrap. Latch g, mul_a=req_a[g], mul_b=req_b[g]. Next cycle: req_ready[g]=1 (one cycle), mul_start=1, busy=1. Set rr_ptr=(g+1) mod N_REQ. Go to RUN.
  - RUN: mul_start held at 1 and operands held; watchdog increments each cycle.
    - If mul_done=1: capture mul_product and go to RESP.
    - Else if watchdog==TIMEOUT: go to ERR.
    - mul_done wins when both conditions hold on the same cycle.
  - RESP: one cycle. rsp_valid[g]=1, rsp_product=captured product, rsp_err=0, mul_start=0. Go to GAP.
  - ERR: one cycle. rsp_valid[g]=1, rsp_product=0, rsp_err=1, mul_start=0. Go to GAP.
  - GAP: mul_start=0. Stay until mul_done=0, then go to IDLE. At least one cycle is spent here, so the multiplier always sees start low between jobs.
- Requester rule: drop req_valid, or present the next job, on the edge after req_ready. A new request from the same requester is arbitrated only on the next IDLE visit.
- Fairness: a requester that keeps req_valid high is served at most once per round when others are pending.
- Latency: request to req_ready is 1 cycle. Response arrives 2 cycles after mul_done is sampled. Minimum turnaround between starts is 3 cycles plus the multiplier latency.
- Watchdog clears on entry to RUN. Its width is clog2(TIMEOUT+1).
- Widths:
  - Operands pass through unmodified, two's complement.
  - Product is 2*DW and passes through unmodified; the block does no sign extension or arithmetic.
  - rr_ptr is clog2(N_REQ) bits and wraps from N_REQ-1 to 0.
- req_valid bits that change while not in IDLE are ignored.
- Extra mul_done pulses arriving outside RUN are ignored.

Decomposition:
- Package booth_share_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_RESP, ST_ERR, ST_GAP;
  - default N_REQ, DW, TIMEOUT;
  - clog2 function.
- Sub-module rr_pick: combinational round-robin first-set search taking (req vector, rr_ptr) and returning (any, grant index). Instantiated once.

Test Plan:
- Bench model: behavioural booth multiplier with 10-cycle latency, plus a stuck variant.
- Single requester 0, A=2, B=4 -> req_ready[0] 1 cycle after request; rsp_valid[0] with rsp_product=0x0008, rsp_err=0; mul_start low for >=1 cycle afterwards.
- Requesters 0..3 all valid simultaneously: (-4)*5, 36*(-8), (-127)*(-127), 2*4 -> grants in order 0,1,2,3. Products 0xFFEC, 0xFEE0, 0x3F01, 0x0008 routed to the matching rsp_valid bit.
- rr_ptr=2 (previous grant to 1), requesters 0 and 3 valid -> 3 is granted before 0.
- Stuck multiplier (mul_done never high) -> rsp_valid[g] with rsp_err=1 and rsp_product=0 exactly TIMEOUT+1 cycles after mul_start rises. Next request then proceeds normally with the good model.
- rst_n asserted in RUN -> all outputs go to 0 immediately with no rsp_valid. After release, a new 2*4 request completes with 0x0008.
- mul_done held high into GAP for 3 cycles -> controller stays in GAP and does not re-issue mul_start until mul_done falls.
